nv_nvdla_sdp_core_y_inp_chn_out_tx: RTL and testbench

NV_NVDLA_SDP_CORE_Y_INP_CHN_OUT_TX -- requirements
Module: nv_nvdla_sdp_core_y_inp_chn_out_tx

---
 rtl/nv_nvdla_sdp_core_y_inp_chn_out_tx.sv | 113 +++++++++++
 tb/tb_nv_nvdla_sdp_core_y_inp_chn_out_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_sdp_core_y_inp_chn_out_tx.sv
// SDP Y-input channel output transmitter: 2-entry valid/ready skid FIFO between core and consumer.
// Optional stall counter enabled by defining SDP_Y_INP_OUT_STALL_CNT_EN.
module nv_nvdla_sdp_core_y_inp_chn_out_tx #(
    parameter int WIDTH = 512
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             chn_out_rsci_oswt,
    input  logic             core_wen,
    input  logic [WIDTH-1:0] chn_out_rsci_d,
    output logic             chn_out_rsci_bawt,
    output logic             chn_out_rsci_wen_comp,
    output logic [WIDTH-1:0] chn_out_rsc_z,
    output logic             chn_out_rsc_lz,
    input  logic             chn_out_rsc_vz,
    input  logic             stall_cnt_clr,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] hold_q;
    logic             push;
    logic             pop;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Outputs: handshake flags decode registered state only, so vz never reaches bawt.
    always_comb begin
        chn_out_rsci_bawt     = (state_q != FULL);
        chn_out_rsc_lz        = (state_q != EMPTY);
        chn_out_rsci_wen_comp = ~chn_out_rsci_oswt | chn_out_rsci_bawt;
        push                  = chn_out_rsci_oswt & core_wen & chn_out_rsci_bawt;
        pop                   = chn_out_rsc_lz & chn_out_rsc_vz;
        chn_out_rsc_z         = (state_q == EMPTY) ? hold_q : mem_q[rd_ptr_q];
    end

    // Storage and pointers; hold_q tracks the head so z keeps its last value once drained.
    // NOTE: storage is reset explicitly because z must read 0 after reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            hold_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= chn_out_rsci_d;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (chn_out_rsc_lz) begin
                hold_q <= mem_q[rd_ptr_q];
            end
        end
    end

`ifdef SDP_Y_INP_OUT_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Counts cycles where data is offered but not taken; saturates, clear has priority.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || stall_cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (chn_out_rsc_lz && !chn_out_rsc_vz && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_stall_cnt_clr;

    assign unused_stall_cnt_clr = stall_cnt_clr;
    assign stall_cnt            = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_core_y_inp_chn_out_tx.sv
// Directed self-checking bench for nv_nvdla_sdp_core_y_inp_chn_out_tx (WIDTH=512).
// Stall-count expectations follow SDP_Y_INP_OUT_STALL_CNT_EN as compiled.
module tb_nv_nvdla_sdp_core_y_inp_chn_out_tx;
    localparam int W = 512;

    logic         clk = 1'b0;
    logic         rst;
    logic         oswt;
    logic         wen;
    logic [W-1:0] d;
    logic         bawt;
    logic         wen_comp;
    logic [W-1:0] z;
    logic         lz;
    logic         vz;
    logic         clr;
    logic [31:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nv_nvdla_sdp_core_y_inp_chn_out_tx #(.WIDTH(W)) dut (
        .nvdla_core_clk        (clk),
        .nvdla_core_rst        (rst),
        .chn_out_rsci_oswt     (oswt),
        .core_wen              (wen),
        .chn_out_rsci_d        (d),
        .chn_out_rsci_bawt     (bawt),
        .chn_out_rsci_wen_comp (wen_comp),
        .chn_out_rsc_z         (z),
        .chn_out_rsc_lz        (lz),
        .chn_out_rsc_vz        (vz),
        .stall_cnt_clr         (clr),
        .stall_cnt             (stall_cnt)
    );

`ifdef SDP_Y_INP_OUT_STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic o, input logic w, input logic [31:0] dv, input logic v);
        oswt = o;
        wen  = w;
        d    = W'(dv);
        vz   = v;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        do_reset();
        total++; if (lz !== 1'b0) begin bad++; $display("FAIL reset_lz: got %b want 0", lz); end
        total++; if (z !== '0) begin bad++; $display("FAIL reset_z: got %h want 0", z[31:0]); end
        total++; if (bawt !== 1'b1) begin bad++; $display("FAIL reset_bawt: got %b want 1", bawt); end
        total++; if (wen_comp !== 1'b1) begin bad++; $display("FAIL reset_wen_comp: got %b want 1", wen_comp); end
        total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL reset_stall: got %h want 0", stall_cnt); end
    endtask

    task automatic test_single();
        drive(1'b1, 1'b1, 32'hA5, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        total++; if (lz !== 1'b1) begin bad++; $display("FAIL single_lz: got %b want 1", lz); end
        total++; if (z !== W'(32'hA5)) begin bad++; $display("FAIL single_z: got %h want a5", z[31:0]); end
        tick();
        total++; if (lz !== 1'b0) begin bad++; $display("FAIL single_drain_lz: got %b want 0", lz); end
        total++; if (z !== W'(32'hA5)) begin bad++; $display("FAIL single_hold_z: got %h want a5", z[31:0]); end
    endtask

    task automatic test_order();
        drive(1'b1, 1'b1, 32'h11, 1'b0);
        tick();
        total++; if (bawt !== 1'b1) begin bad++; $display("FAIL order_bawt_one: got %b want 1", bawt); end
        drive(1'b1, 1'b1, 32'h22, 1'b0);
        tick();
        total++; if (bawt !== 1'b0) begin bad++; $display("FAIL order_bawt_full: got %b want 0", bawt); end
        drive(1'b1, 1'b1, 32'h99, 1'b0);
        total++; if (wen_comp !== 1'b0) begin bad++; $display("FAIL order_wen_comp: got %b want 0", wen_comp); end
        tick();
        total++; if (z !== W'(32'h11)) begin bad++; $display("FAIL order_head: got %h want 11", z[31:0]); end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (wen_comp !== 1'b1) begin bad++; $display("FAIL order_wen_comp_idle: got %b want 1", wen_comp); end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        total++; if (z !== W'(32'h22) || lz !== 1'b1) begin bad++; $display("FAIL order_second: got z=%h lz=%b want z=22 lz=1", z[31:0], lz); end
        tick();
        total++; if (lz !== 1'b0) begin bad++; $display("FAIL order_empty: got %b want 0", lz); end
    endtask

    task automatic test_push_pop();
        drive(1'b1, 1'b1, 32'h44, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h33, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (z !== W'(32'h33)) begin bad++; $display("FAIL pushpop_z: got %h want 33", z[31:0]); end
        total++; if (lz !== 1'b1 || bawt !== 1'b1) begin bad++; $display("FAIL pushpop_one: got lz=%b bawt=%b want 1 1", lz, bawt); end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        total++; if (lz !== 1'b0) begin bad++; $display("FAIL pushpop_drain: got %b want 0", lz); end
    endtask

    task automatic test_full_stall();
        logic [31:0] exp_cnt;
        do_reset();
        drive(1'b1, 1'b1, 32'h55, 1'b0);
        tick();
        clr = 1'b1;
        drive(1'b1, 1'b1, 32'h66, 1'b0);
        tick();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'h77, 1'b0);
            tick();
        end
        exp_cnt = CNT_ON ? 32'd5 : 32'd0;
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL full_stall_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
        total++; if (z !== W'(32'h55) || bawt !== 1'b0) begin bad++; $display("FAIL full_hold: got z=%h bawt=%b want 55 0", z[31:0], bawt); end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        total++; if (z !== W'(32'h66)) begin bad++; $display("FAIL full_second: got %h want 66", z[31:0]); end
        tick();
        total++; if (lz !== 1'b0 || z !== W'(32'h66)) begin bad++; $display("FAIL full_no_extra: got lz=%b z=%h want 0 66", lz, z[31:0]); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 32'h81, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h82, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h83, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total++; if (lz !== 1'b0 || bawt !== 1'b1) begin bad++; $display("FAIL rstmid_flags: got lz=%b bawt=%b want 0 1", lz, bawt); end
        total++; if (stall_cnt !== 32'h0 || z !== '0) begin bad++; $display("FAIL rstmid_clear: got cnt=%h z=%h want 0 0", stall_cnt, z[31:0]); end
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b1, 32'h90, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
`ifdef SDP_Y_INP_OUT_STALL_CNT_EN
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        tick();
        total++; if (stall_cnt !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sat_step: got %h want fffffffe", stall_cnt); end
        tick();
        total++; if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_max: got %h want ffffffff", stall_cnt); end
        tick();
        total++; if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold: got %h want ffffffff", stall_cnt); end
`else
        for (int i = 0; i < 3; i++) tick();
        total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL sat_off: got %h want 0", stall_cnt); end
`endif
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL sat_clear: got %h want 0", stall_cnt); end
        tick();
        total++; if (stall_cnt !== (CNT_ON ? 32'd1 : 32'd0)) begin bad++; $display("FAIL sat_restart: got %h want %h", stall_cnt, CNT_ON ? 32'd1 : 32'd0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_push_pop();
        test_full_stall();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
